// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and flag bit positions for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SBC   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_PASSA = 4'h8;
  localparam logic [3:0] OP_PASSB = 4'h9;
  localparam logic [3:0] OP_NEG   = 4'hA;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_RSVD  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int NFLG  = 4;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the decoder, the ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_hi;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, op, out_ready,
    input  in_ready, out_valid, c, c_hi, carry_out, zero, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, op, out_ready,
    output in_ready, out_valid, c, c_hi, carry_out, zero, negative, overflow
  );
endinterface

// File: rtl/alu_seq_core.sv
// Combinational single-cycle ops (0x0-0xB, 0xF) on latched operands; other codes pass a.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH:0] a_x, b_x, cin_x, sum, diff;

  assign a_x   = {1'b0, a_i};
  assign b_x   = {1'b0, b_i};
  assign cin_x = {{WIDTH{1'b0}}, carry_i};

  always_comb begin
    result_o   = a_i;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    sum        = a_x + b_x + ((op_i == OP_ADC) ? cin_x : '0);
    diff       = a_x - b_x - ((op_i == OP_SBC) ? cin_x : '0);
    case (op_i)
      OP_ADD, OP_ADC: begin
        result_o   = sum[WIDTH-1:0];
        carry_o    = sum[WIDTH];
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        result_o   = diff[WIDTH-1:0];
        carry_o    = diff[WIDTH];
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_OR:    result_o = a_i | b_i;
      OP_AND:   result_o = a_i & b_i;
      OP_NOT:   result_o = ~a_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_PASSB: result_o = b_i;
      OP_NEG: begin
        result_o   = '0 - a_i;
        carry_o    = |a_i;
        overflow_o = (a_i == {1'b1, {(WIDTH-1){1'b0}}});
      end
      // Compare flags come from the a-b difference, not from the -1/0/1 result.
      OP_CMP: begin
        result_o   = diff[WIDTH] ? '1 : ((diff[WIDTH-1:0] == '0) ? '0 : WIDTH'(1));
        carry_o    = diff[WIDTH];
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with iterative shifts; op 0xE is a shift-add multiply
// only when ALU_SEQ_MUL_EN is defined, otherwise it behaves as pass a.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q;
  logic             cin_q, sc_q, sv_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] c_q, c_hi_q;
  logic [NFLG-1:0]  flags_q;

  logic [WIDTH-1:0] core_res, c_d, c_hi_d;
  logic             core_carry, core_ovf, carry_d, ovf_d;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] p_hi_q, p_lo_q;
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
`endif

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (a_q),
    .b_i        (b_q),
    .carry_i    (cin_q),
    .op_i       (op_q),
    .result_o   (core_res),
    .carry_o    (core_carry),
    .overflow_o (core_ovf)
  );

  always_comb begin
    c_d     = core_res;
    c_hi_d  = '0;
    carry_d = core_carry;
    ovf_d   = core_ovf;
    if (is_shift(op_q)) begin
      c_d     = sh_q;
      carry_d = sc_q;
      ovf_d   = (op_q == OP_SHL) ? sv_q : 1'b0;
    end
`ifdef ALU_SEQ_MUL_EN
    if (op_q == OP_MUL) begin
      c_d     = p_lo_q;
      c_hi_d  = p_hi_q;
      carry_d = |p_hi_q;
      ovf_d   = |p_hi_q;
    end
`endif
  end

  // Every accepted op passes through RUN; the counter is 0 for single-cycle ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      op_q        <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      sc_q        <= 1'b0;
      sv_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      c_hi_q      <= '0;
      flags_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
      p_hi_q      <= '0;
      p_lo_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            cin_q      <= bus.carry_in;
            op_q       <= bus.op;
            sh_q       <= bus.a;
            sc_q       <= bus.carry_in;
            sv_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
            if (is_shift(bus.op)) cnt_q <= {1'b0, bus.b[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
            else if (bus.op == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
            else cnt_q <= '0;
`ifdef ALU_SEQ_MUL_EN
            p_hi_q <= '0;
            p_lo_q <= bus.b;
`endif
          end
        end
        ST_RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            if (op_q == OP_SHL) begin
              sh_q <= {sh_q[WIDTH-2:0], 1'b0};
              sc_q <= sh_q[WIDTH-1];
              sv_q <= sv_q | (sh_q[WIDTH-1] ^ sh_q[WIDTH-2]);
            end else if (op_q == OP_SHR) begin
              sh_q <= {1'b0, sh_q[WIDTH-1:1]};
              sc_q <= sh_q[0];
            end
`ifdef ALU_SEQ_MUL_EN
            else if (op_q == OP_MUL) begin
              p_hi_q <= mul_sum[WIDTH:1];
              p_lo_q <= {mul_sum[0], p_lo_q[WIDTH-1:1]};
            end
`endif
          end else begin
            c_q            <= c_d;
            c_hi_q         <= c_hi_d;
            flags_q[FLG_C] <= carry_d;
            flags_q[FLG_Z] <= (c_d == '0);
            flags_q[FLG_N] <= c_d[WIDTH-1];
            flags_q[FLG_V] <= ovf_d;
            out_valid_q    <= 1'b1;
            state_q        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.c_hi      = c_hi_q;
  assign bus.carry_out = flags_q[FLG_C];
  assign bus.zero      = flags_q[FLG_Z];
  assign bus.negative  = flags_q[FLG_N];
  assign bus.overflow  = flags_q[FLG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8; multiply expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] c_hi;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic [7:0] lat;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  res_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    res_t r;
    logic [8:0] t;
    logic [15:0] p;
    int k;
    r = '0;
    r.lat = 8'd1;
    k = int'(b[2:0]);
    case (op)
      4'h0, 4'h1: begin
        t = {1'b0, a} + {1'b0, b} + ((op == 4'h1) ? {8'b0, cin} : 9'b0);
        r.c = t[7:0]; r.carry = t[8];
        r.ovf = (a[7] == b[7]) && (t[7] != a[7]);
      end
      4'h2, 4'h3, 4'hB: begin
        t = {1'b0, a} - {1'b0, b} - ((op == 4'h3) ? {8'b0, cin} : 9'b0);
        r.c = t[7:0]; r.carry = t[8];
        r.ovf = (a[7] != b[7]) && (t[7] != a[7]);
        if (op == 4'hB) r.c = (a < b) ? 8'hFF : ((a == b) ? 8'h00 : 8'h01);
      end
      4'h4: r.c = a | b;
      4'h5: r.c = a & b;
      4'h6: r.c = ~a;
      4'h7: r.c = a ^ b;
      4'h9: r.c = b;
      4'hA: begin r.c = 8'h00 - a; r.carry = (a != 0); r.ovf = (a == 8'h80); end
      4'hC: begin
        r.lat = 8'(1 + k);
        r.c = a << k;
        r.carry = (k == 0) ? cin : a[8-k];
        for (int j = 1; j <= k; j++) if (a[7-j] != a[7]) r.ovf = 1'b1;
      end
      4'hD: begin
        r.lat = 8'(1 + k);
        r.c = a >> k;
        r.carry = (k == 0) ? cin : a[k-1];
      end
`ifdef ALU_SEQ_MUL_EN
      4'hE: begin
        p = {8'b0, a} * {8'b0, b};
        r.c = p[7:0]; r.c_hi = p[15:8];
        r.carry = |p[15:8]; r.ovf = |p[15:8];
        r.lat = 8'd9;
      end
`endif
      default: r.c = a;
    endcase
    r.zero = (r.c == 8'h00);
    r.neg  = r.c[7];
    return r;
  endfunction

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.op = op; bus.a = a; bus.b = b; bus.carry_in = cin; bus.in_valid = 1'b1;
    sb.push_back(model(op, a, b, cin));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output res_t r);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (bus.out_valid !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", bus.out_valid);
    end
    r.c = bus.c; r.c_hi = bus.c_hi; r.carry = bus.carry_out; r.zero = bus.zero;
    r.neg = bus.negative; r.ovf = bus.overflow; r.lat = 8'(lat);
  endtask

  task automatic take_output();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.c, bus.c_hi, bus.carry_out, bus.zero, bus.negative, bus.overflow}
        !== {1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b c=%h c_hi=%h flags=%b%b%b%b required 1 0 00 00 0000",
               bus.in_ready, bus.out_valid, bus.c, bus.c_hi, bus.carry_out, bus.zero, bus.negative, bus.overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    res_t got, exp;
    send(OP_ADD, 8'hFF, 8'h01, 1'b0);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL add_ff_01: got %h required %h", got, exp); end
    n_chk++;
    if ({got.c, got.carry, got.zero, got.ovf, got.lat} !== {8'h00, 1'b1, 1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL add_const: c=%h carry=%b zero=%b ovf=%b lat=%0d required 00 1 1 0 1",
               got.c, got.carry, got.zero, got.ovf, got.lat);
    end
  endtask

  task automatic test_sub();
    res_t got, exp;
    send(OP_SBC, 8'h10, 8'h01, 1'b1);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp || got.c !== 8'h0E || got.carry !== 1'b0) begin
      n_fail++; $display("FAIL sbc_10_01: got %h required %h (c=0e carry=0)", got, exp);
    end
    send(OP_SUB, 8'h80, 8'h01, 1'b0);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp || got.c !== 8'h7F || got.ovf !== 1'b1) begin
      n_fail++; $display("FAIL sub_80_01: got %h required %h (c=7f ovf=1)", got, exp);
    end
  endtask

  task automatic test_shift();
    res_t got, exp;
    send(OP_SHL, 8'h81, 8'h03, 1'b0);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp || {got.c, got.carry, got.ovf, got.lat} !== {8'h08, 1'b0, 1'b1, 8'd4}) begin
      n_fail++; $display("FAIL shl_81_3: got %h required %h (c=08 carry=0 ovf=1 lat=4)", got, exp);
    end
    send(OP_SHR, 8'h81, 8'h00, 1'b1);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp || {got.c, got.carry, got.lat} !== {8'h81, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL shr_81_0: got %h required %h (c=81 carry=1 lat=1)", got, exp);
    end
    send(OP_SHR, 8'hC4, 8'h07, 1'b0);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL shr_c4_7: got %h required %h", got, exp); end
  endtask

  task automatic test_mul();
    res_t got, exp;
    send(OP_MUL, 8'hFF, 8'hFF, 1'b0);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
`ifdef ALU_SEQ_MUL_EN
    if (got !== exp || {got.c_hi, got.c, got.carry, got.ovf, got.lat} !== {8'hFE, 8'h01, 1'b1, 1'b1, 8'd9}) begin
      n_fail++; $display("FAIL mul_ff_ff: got %h required %h (hi=fe c=01 carry=ovf=1 lat=9)", got, exp);
    end
`else
    if (got !== exp || {got.c_hi, got.c, got.lat} !== {8'h00, 8'hFF, 8'd1}) begin
      n_fail++; $display("FAIL mul_ff_ff: got %h required %h (hi=00 c=ff lat=1)", got, exp);
    end
`endif
  endtask

  task automatic test_hold();
    res_t got, exp;
    send(OP_XOR, 8'hA5, 8'h0F, 1'b0);
    wait_result(got);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 8'(i * 17); bus.b = 8'h33;
      @(posedge clk); #1;
      n_chk++;
      if ({bus.out_valid, bus.in_ready, bus.c, bus.c_hi, bus.carry_out, bus.zero, bus.negative, bus.overflow}
          !== {1'b1, 1'b0, got.c, got.c_hi, got.carry, got.zero, got.neg, got.ovf}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b c=%h required 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.c, got.c);
      end
    end
    bus.in_valid = 1'b0;
    take_output();
    n_chk++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL hold_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL hold_result: got %h required %h", got, exp); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_no_extra: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
`ifdef ALU_SEQ_MUL_EN
    send(OP_MUL, 8'h37, 8'h5A, 1'b0);
`else
    send(OP_SHL, 8'h37, 8'h07, 1'b0);
`endif
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.c, bus.c_hi, bus.carry_out, bus.zero, bus.negative, bus.overflow}
        !== {1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b c=%h c_hi=%h required 1 0 00 00",
               bus.in_ready, bus.out_valid, bus.c, bus.c_hi);
    end
    send(OP_ADD, 8'h40, 8'h40, 1'b0);
    wait_result(got);
    take_output();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp || {got.c, got.ovf, got.neg} !== {8'h80, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL add_after_reset: got %h required %h", got, exp);
    end
  endtask

  task automatic test_random();
    res_t got, exp;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
      wait_result(got);
      take_output();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL random_%0d: got %h required %h", i, got, exp); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'h0;
    bus.a = 8'h00; bus.b = 8'h00; bus.carry_in = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_mul();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
